// File: rtl/uo_tx_pkg.sv
// Shared types and pad-ring pin offsets for the uo serial transmitter.
// Pin offsets are relative to LANES, the first pin above the data lanes.
package uo_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int UO_W          = 17;
    localparam int PIN_VALID_OFS = 0;
    localparam int PIN_SOF_OFS   = 1;
    localparam int PIN_EOF_OFS   = 2;
    localparam int PIN_PAR_OFS   = 3;
    localparam int PIN_STB_OFS   = 4;

    // Counter width that stays at least one bit when the count range collapses to 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uo_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty come from pointer compare.
// Read data is the head entry's storage flops, so a pop hands the word over with no extra cycle.
module uo_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uo_serial_tx.sv
// Core-side transmitter: buffers words from a valid/ready stream and drives them onto
// the uo pad bus as framed LANES-wide beats with valid/sof/eof/parity/strobe pins.
module uo_serial_tx
    import uo_tx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 1
) (
    input  logic                          io_clock,
    input  logic                          io_reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic [16:0]                   uo_CORE2PAD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int NBEATS = DATA_W / LANES;
    localparam int BEAT_W = cnt_w(NBEATS);
    localparam int DIV_W  = cnt_w(CLK_DIV);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(NBEATS - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);

    if (LANES < 1 || LANES > 12) begin : g_bad_lanes
        $error("uo_serial_tx: LANES must be in 1..12");
    end
    if (DATA_W % LANES != 0) begin : g_bad_width
        $error("uo_serial_tx: DATA_W must be a multiple of LANES");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uo_serial_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("uo_serial_tx: CLK_DIV must be >= 1");
    end

    // Stream handshake: a word transfers on any edge where s_valid && s_ready; s_ready is
    // !full from registered pointers only, so it never looks at s_valid or a same-cycle pop.
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;

    assign s_ready = !fifo_full;
    assign push    = s_valid && !fifo_full;

    uo_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (io_clock),
        .rst     (io_reset),
        .wr_en   (push),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [UO_W-1:0]     uo_q, uo_d;
    logic [LANES-1:0]    lane_data;
    logic                beat_start;

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            div_q   <= '0;
            shift_q <= '0;
            uo_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            uo_q    <= uo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        div_d   = div_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    beat_d  = '0;
                    div_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (beat_q == BEAT_MAX) begin
                        // Chain straight into the next frame when a word is waiting.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_rd_data;
                            beat_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        shift_d = shift_q >> LANES;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad pins are registered one stage behind the FSM, so nothing from s_* reaches uo.
    assign lane_data  = shift_q[LANES-1:0];
    assign beat_start = (state_q == SEND) && (div_q == '0);

    always_comb begin
        uo_d = '0;
        if (state_q == SEND) begin
            uo_d[LANES-1:0]             = lane_data;
            uo_d[LANES + PIN_VALID_OFS] = 1'b1;
            uo_d[LANES + PIN_SOF_OFS]   = (beat_q == '0);
            uo_d[LANES + PIN_EOF_OFS]   = (beat_q == BEAT_MAX);
            uo_d[LANES + PIN_PAR_OFS]   = ^lane_data;
        end
        uo_d[LANES + PIN_STB_OFS] = uo_q[LANES + PIN_STB_OFS] ^ beat_start;
    end

    assign uo_CORE2PAD = uo_q;
    assign busy        = (state_q == SEND) || !fifo_empty;

endmodule
